// File: rtl/stdcell_vector_checker.sv
// Exhaustive standard-cell vector checker: walks every input vector, waits
// SETTLE_CYCLES, compares the cell output with a captured truth table and
// counts mismatches.
// Optional feature macro: STDCELL_CHK_FIRST_FAIL_EN adds first-fail capture.
module stdcell_vector_checker #(
  parameter int unsigned NUM_INPUTS    = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [(1<<NUM_INPUTS)-1:0] truth_table,
  output logic [NUM_INPUTS-1:0]     cell_in,
  input  logic                      cell_out,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [NUM_INPUTS:0]       err_count
`ifdef STDCELL_CHK_FIRST_FAIL_EN
  ,
  output logic                      first_fail_valid,
  output logic [NUM_INPUTS-1:0]     first_fail_vec
`endif
);

  localparam int unsigned NUM_VECS = 1 << NUM_INPUTS;
  localparam int unsigned ERR_W    = NUM_INPUTS + 1;
  localparam int unsigned CNT_W    = 4;
  localparam logic [NUM_INPUTS-1:0] LAST_VEC = {NUM_INPUTS{1'b1}};
  localparam logic [CNT_W-1:0] SETTLE_LAST =
    CNT_W'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, DONE} state_t;

  state_t                  state_q, state_d;
  logic [NUM_INPUTS-1:0]   vec_q, vec_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_VECS-1:0]     tt_q, tt_d;
  logic [NUM_INPUTS-1:0]   cell_in_d;
  logic                    busy_d, done_d, pass_d;
  logic [ERR_W-1:0]        err_d;
  logic                    run_active;
  logic                    mismatch;
`ifdef STDCELL_CHK_FIRST_FAIL_EN
  logic                    ffv_d;
  logic [NUM_INPUTS-1:0]   ffvec_d;
`endif

  // Next-state and next-output decode; abort of an active run takes priority.
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    cnt_d     = cnt_q;
    tt_d      = tt_q;
    cell_in_d = cell_in;
    done_d    = done;
    pass_d    = pass;
    err_d     = err_count;
`ifdef STDCELL_CHK_FIRST_FAIL_EN
    ffv_d     = first_fail_valid;
    ffvec_d   = first_fail_vec;
`endif
    run_active = (state_q == APPLY) || (state_q == SETTLE) || (state_q == CHECK);
    mismatch   = (cell_out != tt_q[vec_q]);

    if (abort && (run_active || state_q == DONE)) begin
      state_d   = IDLE;
      cell_in_d = '0;
      done_d    = 1'b0;
      pass_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d = APPLY;
            tt_d    = truth_table;
            vec_d   = '0;
            err_d   = '0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
`ifdef STDCELL_CHK_FIRST_FAIL_EN
            ffv_d   = 1'b0;
`endif
          end
        end
        APPLY: begin
          cell_in_d = vec_q;
          cnt_d     = '0;
          state_d   = (SETTLE_CYCLES > 0) ? SETTLE : CHECK;
        end
        SETTLE: begin
          if (cnt_q == SETTLE_LAST) state_d = CHECK;
          else                      cnt_d   = CNT_W'(cnt_q + 1'b1);
        end
        CHECK: begin
          if (mismatch) begin
            err_d = ERR_W'(err_count + 1'b1);
`ifdef STDCELL_CHK_FIRST_FAIL_EN
            if (!first_fail_valid) begin
              ffv_d   = 1'b1;
              ffvec_d = vec_q;
            end
`endif
          end
          if (vec_q == LAST_VEC) begin
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            vec_d   = NUM_INPUTS'(vec_q + 1'b1);
            state_d = APPLY;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == APPLY) || (state_d == SETTLE) || (state_d == CHECK);
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      vec_q     <= '0;
      cnt_q     <= '0;
      tt_q      <= '0;
      cell_in   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      cnt_q     <= cnt_d;
      tt_q      <= tt_d;
      cell_in   <= cell_in_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
      err_count <= err_d;
    end
  end

`ifdef STDCELL_CHK_FIRST_FAIL_EN
  // First mismatching vector of the current run.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else begin
      first_fail_valid <= ffv_d;
      first_fail_vec   <= ffvec_d;
    end
  end
`endif

endmodule

// File: tb/tb_stdcell_vector_checker.sv
// Scoreboard bench: instance a is a 2-input and2 checker (settle 2),
// instance b a 4-input nand4 checker (settle 0).
module tb_stdcell_vector_checker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start_a, abort_a, cout_a, busy_a, done_a, pass_a;
  logic [3:0] tt_a;
  logic [1:0] cin_a;
  logic [2:0] err_a;
  logic        start_b, abort_b, cout_b, busy_b, done_b, pass_b;
  logic [15:0] tt_b;
  logic [3:0]  cin_b;
  logic [4:0]  err_b;
`ifdef STDCELL_CHK_FIRST_FAIL_EN
  logic       ffv_a, ffv_b;
  logic [1:0] ffvec_a;
  logic [3:0] ffvec_b;
`endif

  assign cout_a = &cin_a;
  assign cout_b = ~&cin_b;

  stdcell_vector_checker #(.NUM_INPUTS(2), .SETTLE_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
    .truth_table(tt_a), .cell_in(cin_a), .cell_out(cout_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a)
`ifdef STDCELL_CHK_FIRST_FAIL_EN
    , .first_fail_valid(ffv_a), .first_fail_vec(ffvec_a)
`endif
  );

  stdcell_vector_checker #(.NUM_INPUTS(4), .SETTLE_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
    .truth_table(tt_b), .cell_in(cin_b), .cell_out(cout_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b)
`ifdef STDCELL_CHK_FIRST_FAIL_EN
    , .first_fail_valid(ffv_b), .first_fail_vec(ffvec_b)
`endif
  );

  typedef struct {
    logic pass;
    int   err;
    int   lat;
    logic ffv;
    int   ffvec;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int cyc = 0;
  int st_a = 0;
  int st_b = 0;
  int n_vec = 0;
  int n_miss = 0;
  logic done_a_q = 1'b0;
  logic done_b_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for instance a: compare on each rising edge of done.
  always @(negedge clk) begin
    exp_t e;
    if (done_a && !done_a_q) begin
      if (q_a.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL a_unexpected_done: got done with empty scoreboard");
      end else begin
        e = q_a.pop_front();
        chk("a_pass", pass_a, e.pass);
        chk("a_err", err_a, e.err);
        chk("a_latency", cyc - st_a, e.lat);
`ifdef STDCELL_CHK_FIRST_FAIL_EN
        chk("a_ffv", ffv_a, e.ffv);
        if (e.ffv) chk("a_ffvec", ffvec_a, e.ffvec);
`endif
      end
    end
    done_a_q = done_a;
  end

  // Monitor for instance b.
  always @(negedge clk) begin
    exp_t e;
    if (done_b && !done_b_q) begin
      if (q_b.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL b_unexpected_done: got done with empty scoreboard");
      end else begin
        e = q_b.pop_front();
        chk("b_pass", pass_b, e.pass);
        chk("b_err", err_b, e.err);
        chk("b_latency", cyc - st_b, e.lat);
`ifdef STDCELL_CHK_FIRST_FAIL_EN
        chk("b_ffv", ffv_b, e.ffv);
        if (e.ffv) chk("b_ffvec", ffvec_b, e.ffvec);
`endif
      end
    end
    done_b_q = done_b;
  end

  // Issue a run on a; truth_table is scrambled right after capture.
  task automatic run_a(input logic [3:0] tt, input int err, input logic ffv, input int ffvec);
    exp_t e;
    e.pass = (err == 0); e.err = err; e.lat = 16; e.ffv = ffv; e.ffvec = ffvec;
    q_a.push_back(e);
    @(negedge clk); tt_a = tt; start_a = 1'b1;
    @(posedge clk); #1; st_a = cyc; start_a = 1'b0; tt_a = ~tt;
  endtask

  task automatic run_b(input logic [15:0] tt, input int err, input logic ffv, input int ffvec);
    exp_t e;
    e.pass = (err == 0); e.err = err; e.lat = 32; e.ffv = ffv; e.ffvec = ffvec;
    q_b.push_back(e);
    @(negedge clk); tt_b = tt; start_b = 1'b1;
    @(posedge clk); #1; st_b = cyc; start_b = 1'b0; tt_b = ~tt;
  endtask

  task automatic wait_a();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (q_a.size() == 0) break;
    end
    if (q_a.size() != 0) begin
      n_vec++; n_miss++;
      $display("FAIL a_timeout: got %0d pending runs, required 0", q_a.size());
      q_a.delete();
    end
  endtask

  task automatic wait_b();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (q_b.size() == 0) break;
    end
    if (q_b.size() != 0) begin
      n_vec++; n_miss++;
      $display("FAIL b_timeout: got %0d pending runs, required 0", q_b.size());
      q_b.delete();
    end
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; abort_a = 1'b0; tt_a = '0;
    start_b = 1'b0; abort_b = 1'b0; tt_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_cin", cin_a, 0);
    chk("rst_a_busy", busy_a, 0);
    chk("rst_a_done", done_a, 0);
    chk("rst_a_pass", pass_a, 0);
    chk("rst_a_err", err_a, 0);
    chk("rst_b_busy", busy_b, 0);
    chk("rst_b_err", err_b, 0);
    rst = 1'b0;

    // and2, settle 2
    run_a(4'b1000, 0, 1'b0, 0); wait_a();
    run_a(4'b1001, 1, 1'b1, 0); wait_a();
    run_a(4'b0111, 4, 1'b1, 0); wait_a();
    run_a(4'b0000, 1, 1'b1, 3); wait_a();
    chk("a_cin_hold_done", cin_a, 3);
    chk("a_busy_done", busy_a, 0);

    // start while busy must be ignored
    run_a(4'b1000, 0, 1'b0, 0);
    repeat (5) @(negedge clk);
    chk("a_busy_run", busy_a, 1);
    tt_a = 4'b0000; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    wait_a();

    // abort during CHECK of vector 2, together with start
    @(negedge clk); tt_a = 4'b1001; start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    chk("a_cin_vec2", cin_a, 2);
    abort_a = 1'b1; start_a = 1'b1;
    @(posedge clk); #1;
    abort_a = 1'b0; start_a = 1'b0;
    chk("a_abort_busy", busy_a, 0);
    chk("a_abort_done", done_a, 0);
    chk("a_abort_pass", pass_a, 0);
    chk("a_abort_cin", cin_a, 0);
    chk("a_abort_err", err_a, 1);
    repeat (3) @(negedge clk);
    chk("a_abort_stays_idle", busy_a, 0);
    run_a(4'b1000, 0, 1'b0, 0); wait_a();

    // nand4, settle 0
    run_b(16'h7FFF, 0, 1'b0, 0); wait_b();
    run_b(16'hFFFF, 1, 1'b1, 15); wait_b();
    run_b(16'h7FFE, 1, 1'b1, 0); wait_b();
    run_b(16'h0000, 15, 1'b1, 0); wait_b();
    run_b(16'h8000, 16, 1'b1, 0); wait_b();

    // reset mid-run, asserted together with start
    @(negedge clk); tt_b = 16'h0000; start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    repeat (6) @(negedge clk);
    chk("b_err_before_rst", (err_b != 0), 1);
    rst = 1'b1; start_b = 1'b1; abort_b = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    chk("b_rst_cin", cin_b, 0);
    chk("b_rst_busy", busy_b, 0);
    chk("b_rst_done", done_b, 0);
    chk("b_rst_pass", pass_b, 0);
    chk("b_rst_err", err_b, 0);
`ifdef STDCELL_CHK_FIRST_FAIL_EN
    chk("b_rst_ffv", ffv_b, 0);
`endif
    repeat (2) @(negedge clk);
    chk("b_rst_idle", busy_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
